// File: rtl/llc_rsp_out_arbiter.sv
// llc_rsp_out_arbiter
//   Merges the LLC coherent response stream and the DMA response stream onto a
//   single registered response channel toward the NoC response plane. Each
//   source is buffered by a one-entry holding register; the arbiter prefers
//   coherent responses but forces a DMA grant once STARVE_LIMIT consecutive
//   coherent grants have gone out while a DMA response was waiting.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous active-low reset
//   coh_valid   coherent response valid          coh_ready   coherent accept
//   coh_data    coherent response payload (opaque, DATA_W bits)
//   dma_valid   DMA response valid               dma_ready   DMA accept
//   dma_data    DMA response payload (opaque, DATA_W bits)
//   out_valid   registered output valid          out_ready   downstream ready
//   out_data    registered output payload
//   out_src     source of the current output: 0 = coherent, 1 = DMA
//   starve_cnt  consecutive coherent grants while DMA has been waiting
//
// There is no combinational path from any input payload/valid to the output
// channel: every response passes through its holding register and then the
// output register, giving a minimum latency of two cycles.

module llc_rsp_out_arbiter #(
    parameter int DATA_W       = 640,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              coh_valid,
    output logic              coh_ready,
    input  logic [DATA_W-1:0] coh_data,

    input  logic              dma_valid,
    output logic              dma_ready,
    input  logic [DATA_W-1:0] dma_data,

    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_src,

    output logic [3:0]        starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic              hold_coh_valid;
    logic [DATA_W-1:0] hold_coh_data;
    logic              hold_dma_valid;
    logic [DATA_W-1:0] hold_dma_data;

    logic load;
    logic grant_coh;
    logic grant_dma;
    logic coh_take;
    logic dma_take;

    // The output register can accept a new response when it is empty or is
    // being drained this cycle; no grant is made otherwise, which keeps the
    // output stable under a stall.
    assign load = ~out_valid | out_ready;

    always_comb begin
        grant_coh = 1'b0;
        grant_dma = 1'b0;
        if (load) begin
            if (hold_coh_valid && hold_dma_valid) begin
                if (starve_cnt == LIMIT) begin
                    grant_dma = 1'b1;
                end else begin
                    grant_coh = 1'b1;
                end
            end else if (hold_coh_valid) begin
                grant_coh = 1'b1;
            end else if (hold_dma_valid) begin
                grant_dma = 1'b1;
            end
        end
    end

    // A hold being granted this cycle frees its slot, so it may refill in the
    // same cycle.
    assign coh_ready = ~hold_coh_valid | grant_coh;
    assign dma_ready = ~hold_dma_valid | grant_dma;

    assign coh_take = coh_valid & coh_ready;
    assign dma_take = dma_valid & dma_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_coh_valid <= 1'b0;
            hold_coh_data  <= '0;
        end else if (coh_take) begin
            hold_coh_valid <= 1'b1;
            hold_coh_data  <= coh_data;
        end else if (grant_coh) begin
            hold_coh_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_dma_valid <= 1'b0;
            hold_dma_data  <= '0;
        end else if (dma_take) begin
            hold_dma_valid <= 1'b1;
            hold_dma_data  <= dma_data;
        end else if (grant_dma) begin
            hold_dma_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= 1'b0;
        end else if (load) begin
            if (grant_coh) begin
                out_valid <= 1'b1;
                out_data  <= hold_coh_data;
                out_src   <= 1'b0;
            end else if (grant_dma) begin
                out_valid <= 1'b1;
                out_data  <= hold_dma_data;
                out_src   <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Counts coherent grants that overtook a waiting DMA response. It clears
    // whenever DMA wins or has nothing waiting, so it only ever measures the
    // current wait of the DMA response sitting in its hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (grant_dma || !hold_dma_valid) begin
            starve_cnt <= 4'd0;
        end else if (grant_coh && (starve_cnt != LIMIT)) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_llc_rsp_out_arbiter.sv
module tb_llc_rsp_out_arbiter;

    localparam int W     = 64;
    localparam int LIMIT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         coh_valid, coh_ready, dma_valid, dma_ready;
    logic [W-1:0] coh_data, dma_data, out_data;
    logic         out_valid, out_ready, out_src;
    logic [3:0]   starve_cnt;

    llc_rsp_out_arbiter #(.DATA_W(W), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .coh_valid(coh_valid), .coh_ready(coh_ready), .coh_data(coh_data),
        .dma_valid(dma_valid), .dma_ready(dma_ready), .dma_data(dma_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_src(out_src), .starve_cnt(starve_cnt)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: responses accepted but not yet granted, per source,
    // plus the expected contents of the output channel.
    typedef struct packed {
        logic         src;
        logic [W-1:0] data;
    } exp_t;

    logic [W-1:0] wait_c[$];
    logic [W-1:0] wait_d[$];
    exp_t         exp_q[$];
    logic         m_ov;
    logic         m_src;
    logic [W-1:0] m_data;
    int           m_starve;

    function automatic void model_clear();
        wait_c.delete();
        wait_d.delete();
        exp_q.delete();
        m_ov     = 1'b0;
        m_src    = 1'b0;
        m_data   = '0;
        m_starve = 0;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom};
    endfunction

    // One clock cycle, entered and left just after a falling edge.
    task automatic step(input logic cv, input logic [W-1:0] cd,
                        input logic dv, input logic [W-1:0] dd, input logic ordy);
        logic ld, gc, gd, cr, dr;
        exp_t e;
        chk("out_valid", {63'd0, out_valid}, {63'd0, m_ov});
        if (m_ov) begin
            chk("out_data", out_data, m_data);
            chk("out_src", {63'd0, out_src}, {63'd0, m_src});
        end
        chk("starve_cnt", {60'd0, starve_cnt}, W'(m_starve));
        chk("starve_bound", {63'd0, (starve_cnt <= 4'(LIMIT))}, 64'd1);

        coh_valid = cv; coh_data = cd;
        dma_valid = dv; dma_data = dd;
        out_ready = ordy;
        #1;

        ld = !m_ov || ordy;
        gc = 1'b0;
        gd = 1'b0;
        if (ld) begin
            if (wait_c.size() > 0 && wait_d.size() > 0) begin
                if (m_starve == LIMIT) gd = 1'b1;
                else                   gc = 1'b1;
            end else if (wait_c.size() > 0) begin
                gc = 1'b1;
            end else if (wait_d.size() > 0) begin
                gd = 1'b1;
            end
        end
        cr = (wait_c.size() == 0) || gc;
        dr = (wait_d.size() == 0) || gd;
        chk("coh_ready", {63'd0, coh_ready}, {63'd0, cr});
        chk("dma_ready", {63'd0, dma_ready}, {63'd0, dr});

        if (gd || wait_d.size() == 0) m_starve = 0;
        else if (gc && m_starve < LIMIT) m_starve++;

        if (ld) begin
            if (gc) begin
                m_ov = 1'b1; m_src = 1'b0; m_data = wait_c.pop_front();
            end else if (gd) begin
                m_ov = 1'b1; m_src = 1'b1; m_data = wait_d.pop_front();
            end else begin
                m_ov = 1'b0;
            end
            if (gc || gd) begin
                e.src  = m_src;
                e.data = m_data;
                exp_q.push_back(e);
            end
        end
        if (cv && cr) wait_c.push_back(cd);
        if (dv && dr) wait_d.push_back(dd);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, 1'b1);
    endtask

    // Hold reset low for n cycles with the inputs toggling.
    task automatic reset_hold(input int n);
        for (int i = 0; i < n; i++) begin
            coh_valid = $urandom_range(0, 1); coh_data = rnd();
            dma_valid = $urandom_range(0, 1); dma_data = rnd();
            out_ready = $urandom_range(0, 1);
            #1;
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_coh_ready", {63'd0, coh_ready}, 64'd1);
            chk("rst_dma_ready", {63'd0, dma_ready}, 64'd1);
            chk("rst_starve", {60'd0, starve_cnt}, 64'd0);
            @(negedge clk);
        end
        coh_valid = 1'b0; dma_valid = 1'b0; out_ready = 1'b1;
        model_clear();
        rst = 1'b1;
    endtask

    // Scoreboard monitor: every output handshake must match the next granted
    // response in grant order.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_unexpected: got src %0d data %0h expected no output", out_src, out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_src", {63'd0, out_src}, {63'd0, e.src});
                    chk("sb_data", out_data, e.data);
                end
            end
        end
    end

    initial begin
        logic   srcs[$];
        int     drained;
        logic [3:0] exp_starve [7];
        logic [5:0] exp_src_seq;
        rst = 1'b0;
        coh_valid = 1'b0; dma_valid = 1'b0; out_ready = 1'b1;
        coh_data = '0; dma_data = '0;
        model_clear();
        @(negedge clk);

        // Reset, then first coherent payload reaches the output two cycles later.
        reset_hold(4);
        step(1'b1, 64'h1A, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("first_out_valid", {63'd0, out_valid}, 64'd1);
        chk("first_out_data", out_data, 64'h1A);
        chk("first_out_src", {63'd0, out_src}, 64'd0);
        idle(3);

        // Starvation bound: C,C,C,C,D,C with starve 0,0,1,2,3,4,0.
        exp_starve = '{4'd0, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        exp_src_seq = 6'b010000;
        for (int c = 0; c < 8; c++) begin
            if (c < 7) chk("starve_seq", {60'd0, starve_cnt}, {60'd0, exp_starve[c]});
            if (c >= 2) chk("starve_src_seq", {63'd0, out_src}, {63'd0, exp_src_seq[c-2]});
            step(1'b1, 64'h100 + 64'(c), c == 0, 64'hD0, 1'b1);
        end
        idle(4);

        // Backpressure: one output held, one response per source absorbed.
        for (int c = 0; c < 10; c++) begin
            if (c >= 3) begin
                chk("bp_coh_ready", {63'd0, coh_ready}, 64'd0);
                chk("bp_dma_ready", {63'd0, dma_ready}, 64'd0);
                chk("bp_held_data", out_data, 64'h200);
            end
            step(1'b1, 64'h200 + 64'(c), 1'b1, 64'h300 + 64'(c), 1'b0);
        end
        drained = 0;
        srcs.delete();
        for (int c = 0; c < 6; c++) begin
            if (out_valid) begin
                drained++;
                srcs.push_back(out_src);
            end
            step(1'b0, '0, 1'b0, '0, 1'b1);
        end
        chk("bp_drained", 64'(drained), 64'd3);
        if (srcs.size() == 3) begin
            chk("bp_order0", {63'd0, srcs[0]}, 64'd0);
            chk("bp_order1", {63'd0, srcs[1]}, 64'd0);
            chk("bp_order2", {63'd0, srcs[2]}, 64'd1);
        end

        // Streaming: 100 coherent payloads, no bubbles after the first output.
        for (int c = 0; c < 104; c++) begin
            if (c >= 2 && c < 102) begin
                chk("stream_valid", {63'd0, out_valid}, 64'd1);
                chk("stream_data", out_data, 64'(c - 2));
            end
            step(c < 100, 64'(c), 1'b0, '0, 1'b1);
        end
        idle(2);

        // Random traffic.
        for (int c = 0; c < 10000; c++) begin
            step($urandom_range(0, 3) != 0, rnd(),
                 $urandom_range(0, 2) == 0, rnd(),
                 $urandom_range(0, 3) != 0);
        end
        idle(6);
        chk("rand_exp_q_empty", 64'(exp_q.size()), 64'd0);
        chk("rand_wait_empty", 64'(wait_c.size() + wait_d.size()), 64'd0);

        // Mid-transfer reset with output and both holds full.
        for (int c = 0; c < 3; c++) step(1'b1, 64'hAA0 + 64'(c), 1'b1, 64'hBB0 + 64'(c), 1'b0);
        chk("mid_pre_out_valid", {63'd0, out_valid}, 64'd1);
        chk("mid_pre_coh_ready", {63'd0, coh_ready}, 64'd0);
        #3;
        rst = 1'b0;
        #1;
        chk("mid_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_coh_ready", {63'd0, coh_ready}, 64'd1);
        chk("mid_dma_ready", {63'd0, dma_ready}, 64'd1);
        chk("mid_starve", {60'd0, starve_cnt}, 64'd0);
        model_clear();
        @(negedge clk);
        reset_hold(2);
        step(1'b1, 64'hBEEF, 1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, 1'b1);
        chk("post_rst_valid", {63'd0, out_valid}, 64'd1);
        chk("post_rst_data", out_data, 64'hBEEF);
        idle(2);
        chk("post_rst_valid_end", {63'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
